cm0_pmu_cdc_req_tx: RTL

//  Source (transmitting) end of a 4-phase req/ack CDC handshake used by the PMU.
//  - Turns a one-cycle request in the SRCCLK domain into a level CDCREQ with a stable

---
 rtl/cm0_pmu_cdc_req_tx.sv | 72 +++++++
 1 files changed

// File: rtl/cm0_pmu_cdc_req_tx.sv
// cm0_pmu_cdc_req_tx: source end of a 4-phase req/ack CDC handshake with synchronised ack.
// Optional one-entry pending buffer enabled by CM0_PMU_CDC_REQ_QUEUE_EN.
module cm0_pmu_cdc_req_tx #(
  parameter int DW       = 8,
  parameter int ACK_SYNC = 2
) (
  input  logic          SRCCLK,
  input  logic          SRCRESETn,
  input  logic          SRCREQ,
  input  logic [DW-1:0] SRCDATA,
  output logic          SRCFULL,
  output logic          SRCDONE,
  output logic          CDCREQ,
  output logic [DW-1:0] CDCDATA,
  input  logic          CDCACK
);
  typedef enum logic [1:0] {IDLE, WAITACK, WAITREL} state_e;
  state_e state_q, state_d;
  logic [ACK_SYNC-1:0] ack_sync_q;
  logic ack_s, idle_rdy, launch, req_d, done_d;
  logic [DW-1:0] launch_data, data_d;
  always_ff @(posedge SRCCLK or negedge SRCRESETn)
    if (!SRCRESETn) ack_sync_q <= '0;
    else ack_sync_q <= {ack_sync_q[ACK_SYNC-2:0], CDCACK};
  assign ack_s    = ack_sync_q[ACK_SYNC-1];
  assign idle_rdy = (state_q == IDLE) && !ack_s;
`ifdef CM0_PMU_CDC_REQ_QUEUE_EN
  logic pend_v_q, pend_v_d;
  logic [DW-1:0] pend_data_q, pend_data_d;
  // A buffered request always launches ahead of a new strobe, which then refills the buffer.
  assign launch      = idle_rdy && (SRCREQ || pend_v_q);
  assign launch_data = pend_v_q ? pend_data_q : SRCDATA;
  assign SRCFULL     = pend_v_q && !idle_rdy;
  assign pend_v_d    = idle_rdy ? (pend_v_q && SRCREQ) : (pend_v_q || SRCREQ);
  assign pend_data_d = (SRCREQ && (pend_v_q == idle_rdy)) ? SRCDATA : pend_data_q;
  always_ff @(posedge SRCCLK or negedge SRCRESETn)
    if (!SRCRESETn) begin
      pend_v_q    <= 1'b0;
      pend_data_q <= '0;
    end else begin
      pend_v_q    <= pend_v_d;
      pend_data_q <= pend_data_d;
    end
`else
  assign launch      = idle_rdy && SRCREQ;
  assign launch_data = SRCDATA;
  assign SRCFULL     = (state_q != IDLE) || ack_s;
`endif
  always_ff @(posedge SRCCLK or negedge SRCRESETn)
    if (!SRCRESETn) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = launch                          ? WAITACK :
              (state_q == WAITACK && ack_s)   ? WAITREL :
              (state_q == WAITREL && !ack_s)  ? IDLE    : state_q;
  end
  always_comb begin
    req_d  = (state_d == WAITACK);
    data_d = launch ? launch_data : CDCDATA;
    done_d = (state_q == WAITREL) && !ack_s;
  end
  always_ff @(posedge SRCCLK or negedge SRCRESETn)
    if (!SRCRESETn) begin
      CDCREQ  <= 1'b0;
      CDCDATA <= '0;
      SRCDONE <= 1'b0;
    end else begin
      CDCREQ  <= req_d;
      CDCDATA <= data_d;
      SRCDONE <= done_d;
    end
endmodule
